// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared states, defaults and helpers for the data cache controller
package dcache_ctrl_pkg;

   localparam int DC_LINES     = 4;
   localparam int DC_LINE_BITS = 128;
   localparam int DC_ADDR_W    = 32;

   localparam logic MEM_OP_FILL  = 1'b0;
   localparam logic MEM_OP_WBACK = 1'b1;

   typedef enum logic [1:0] {
      DC_IDLE  = 2'd0,
      DC_WBACK = 2'd1,
      DC_FILL  = 2'd2
   } dc_state_t;

   // Byte enables for a 16-byte line; word stores ignore the low two address bits.
   function automatic logic [15:0] dc_byte_en(input logic [3:0] offset, input logic is_byte);
      if (is_byte)
         return 16'h0001 << offset;
      else
         return 16'h000F << {offset[3:2], 2'b00};
   endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side request and line memory port of the data cache
interface dcache_ctrl_if #(
   parameter int ADDR_W    = 32,
   parameter int LINE_BITS = 128
) ();

   logic [ADDR_W-1:0]    cpu_addr;
   logic                 cpu_r_en;
   logic                 cpu_w_en;
   logic                 cpu_is_byte;
   logic [31:0]          cpu_wdata;
   logic [31:0]          cpu_rdata;
   logic                 block_pipe_data_cache;
   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [LINE_BITS-1:0] mem_wdata;
   logic [LINE_BITS-1:0] mem_rdata;
   logic                 mem_ack;

   modport master (
      output cpu_addr, cpu_r_en, cpu_w_en, cpu_is_byte, cpu_wdata,
      input  cpu_rdata, block_pipe_data_cache,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

   modport slave (
      input  cpu_addr, cpu_r_en, cpu_w_en, cpu_is_byte, cpu_wdata,
      output cpu_rdata, block_pipe_data_cache,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty and line storage with byte-lane store decode
module dcache_array
   import dcache_ctrl_pkg::*;
#(
   parameter int LINES     = DC_LINES,
   parameter int LINE_BITS = DC_LINE_BITS,
   parameter int IDX_W     = 2,
   parameter int TAG_W     = 26
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [IDX_W-1:0]     i_idx,
   output logic                 o_valid,
   output logic                 o_dirty,
   output logic [TAG_W-1:0]     o_tag,
   output logic [LINE_BITS-1:0] o_line,
   input  logic                 i_cpu_we,
   input  logic [3:0]           i_offset,
   input  logic                 i_is_byte,
   input  logic [31:0]          i_wdata,
   input  logic                 i_fill_we,
   input  logic [TAG_W-1:0]     i_fill_tag,
   input  logic [LINE_BITS-1:0] i_fill_line,
   input  logic                 i_clr_dirty
);

   localparam int BYTES = LINE_BITS / 8;

   logic [LINE_BITS-1:0] r_data [LINES];
   logic [TAG_W-1:0]     r_tag  [LINES];
   logic [LINES-1:0]     r_valid;
   logic [LINES-1:0]     r_dirty;

   logic [BYTES-1:0]     w_be;
   logic [LINE_BITS-1:0] w_wline;

   assign w_be    = dc_byte_en(i_offset, i_is_byte);
   assign w_wline = i_is_byte ? {BYTES{i_wdata[7:0]}} : {(LINE_BITS/32){i_wdata}};

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_line  = r_data[i_idx];

   // Data and tags carry no reset; valid gates every use of them.
   always_ff @(posedge i_clk) begin
      if (i_fill_we) begin
         r_data[i_idx] <= i_fill_line;
         r_tag[i_idx]  <= i_fill_tag;
      end else if (i_cpu_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (w_be[b])
               r_data[i_idx][8*b +: 8] <= w_wline[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_we) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_cpu_we) begin
         r_dirty[i_idx] <= 1'b1;
      end else if (i_clr_dirty) begin
         r_dirty[i_idx] <= 1'b0;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller and pipeline stall source
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int LINES     = DC_LINES,
   parameter int LINE_BITS = DC_LINE_BITS,
   parameter int ADDR_W    = DC_ADDR_W
) (
   input  logic         i_clk,
   input  logic         i_reset,
   dcache_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   dc_state_t         r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;

   logic [IDX_W-1:0]     w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_valid;
   logic                 w_dirty;
   logic [TAG_W-1:0]     w_line_tag;
   logic [LINE_BITS-1:0] w_line;
   logic                 w_req;
   logic                 w_hit;
   logic                 w_idle;
   logic                 w_ack;
   logic                 w_cpu_we;
   logic                 w_fill_we;
   logic                 w_clr_dirty;
   logic [31:0]          w_word;
   logic [7:0]           w_byte;

   assign w_idx  = bus.cpu_addr[4+IDX_W-1:4];
   assign w_tag  = bus.cpu_addr[ADDR_W-1:4+IDX_W];
   assign w_req  = bus.cpu_r_en || bus.cpu_w_en;
   assign w_hit  = w_valid && (w_line_tag == w_tag);
   assign w_idle = (r_state == DC_IDLE);
   assign w_ack  = bus.mem_ack && r_mem_req;

   // A request with both enables high is a store.
   assign w_cpu_we    = w_idle && w_hit && bus.cpu_w_en && !i_reset;
   assign w_fill_we   = (r_state == DC_FILL) && w_ack && !i_reset;
   assign w_clr_dirty = (r_state == DC_WBACK) && w_ack;

   dcache_array #(
      .LINES     (LINES),
      .LINE_BITS (LINE_BITS),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_array (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_idx       (w_idx),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_line_tag),
      .o_line      (w_line),
      .i_cpu_we    (w_cpu_we),
      .i_offset    (bus.cpu_addr[3:0]),
      .i_is_byte   (bus.cpu_is_byte),
      .i_wdata     (bus.cpu_wdata),
      .i_fill_we   (w_fill_we),
      .i_fill_tag  (w_tag),
      .i_fill_line (bus.mem_rdata),
      .i_clr_dirty (w_clr_dirty)
   );

   assign w_word = w_line[32*bus.cpu_addr[3:2] +: 32];
   assign w_byte = w_word[8*bus.cpu_addr[1:0] +: 8];

   always_comb begin
      bus.cpu_rdata = 32'd0;
      if (w_idle && w_hit && bus.cpu_r_en && !bus.cpu_w_en)
         bus.cpu_rdata = bus.cpu_is_byte ? {24'd0, w_byte} : w_word;
   end

   // The stall must rise in the miss cycle itself, so it is not registered.
   assign bus.block_pipe_data_cache = !w_idle || (w_req && !w_hit);

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = w_line;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= DC_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         case (r_state)
            DC_IDLE: begin
               if (w_req && !w_hit) begin
                  r_mem_req <= 1'b1;
                  if (w_valid && w_dirty) begin
                     r_state    <= DC_WBACK;
                     r_mem_we   <= MEM_OP_WBACK;
                     r_mem_addr <= {w_line_tag, w_idx, 4'b0000};
                  end else begin
                     r_state    <= DC_FILL;
                     r_mem_we   <= MEM_OP_FILL;
                     r_mem_addr <= {w_tag, w_idx, 4'b0000};
                  end
               end
            end
            DC_WBACK: begin
               if (w_ack) begin
                  r_state    <= DC_FILL;
                  r_mem_we   <= MEM_OP_FILL;
                  r_mem_addr <= {w_tag, w_idx, 4'b0000};
               end
            end
            DC_FILL: begin
               if (w_ack) begin
                  r_state   <= DC_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end
            end
            default: begin
               r_state   <= DC_IDLE;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl against a coherent-memory reference model
module tb_dcache_ctrl;

   localparam int LAT = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic model_ack = 1'b0;
   logic spur_ack = 1'b0;

   always #5 clk = ~clk;

   dcache_ctrl_if #(.ADDR_W(32), .LINE_BITS(128)) mif ();

   assign mif.mem_ack = model_ack | spur_ack;

   dcache_ctrl dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (mif.slave)
   );

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      bit          is_load;
      logic [31:0] rdata;
      int          stall;
      string       name;
   } cpu_exp_t;

   typedef struct {
      bit           we;
      logic [31:0]  addr;
      logic [127:0] wdata;
   } mem_exp_t;

   cpu_exp_t cpu_q[$];
   mem_exp_t mem_q[$];

   logic [31:0] cur_m   [int unsigned];
   logic [31:0] exp_mem [int unsigned];
   logic [31:0] dev_mem [int unsigned];

   bit          m_valid [4];
   bit          m_dirty [4];
   int unsigned m_line  [4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] init_word(input int unsigned a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] get_cur(input int unsigned wa);
      return cur_m.exists(wa) ? cur_m[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] get_exp(input int unsigned wa);
      return exp_mem.exists(wa) ? exp_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] get_dev(input int unsigned wa);
      return dev_mem.exists(wa) ? dev_mem[wa] : init_word(wa);
   endfunction

   // Memory device: ack 5 cycles after the first cycle of each request.
   initial begin
      int cnt = 0;
      mif.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || !mif.mem_req) begin
            model_ack = 1'b0;
            cnt = 0;
         end else if (model_ack) begin
            model_ack = 1'b0;
            cnt = 1;
         end else begin
            cnt++;
            if (cnt == LAT + 1) begin
               model_ack = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  if (mif.mem_we)
                     dev_mem[mif.mem_addr + 4*k] = mif.mem_wdata[32*k +: 32];
                  else
                     mif.mem_rdata[32*k +: 32] = get_dev(mif.mem_addr + 4*k);
               end
            end
         end
      end
   end

   // Monitor: pops expectations whenever a request is served or a memory transaction completes.
   initial begin
      int stall_cnt = 0;
      cpu_exp_t e;
      mem_exp_t m;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_cnt = 0;
         end else begin
            if (mif.mem_req && mem_q.size() == 0)
               chk("unexpected_mem_req", mif.mem_req, 1'b0);
            if (mif.mem_req && mif.mem_ack) begin
               if (mem_q.size() == 0) begin
                  chk("mem_txn_expected", mem_q.size(), 1);
               end else begin
                  m = mem_q.pop_front();
                  chk("mem_we", mif.mem_we, m.we);
                  chk("mem_addr", mif.mem_addr, m.addr);
                  if (m.we)
                     chk("mem_wdata", mif.mem_wdata, m.wdata);
               end
            end
            if (mif.cpu_r_en || mif.cpu_w_en) begin
               if (mif.block_pipe_data_cache) begin
                  stall_cnt++;
               end else if (cpu_q.size() != 0) begin
                  e = cpu_q.pop_front();
                  chk({e.name, "_stall"}, stall_cnt, e.stall);
                  if (e.is_load)
                     chk({e.name, "_rdata"}, mif.cpu_rdata, e.rdata);
                  stall_cnt = 0;
               end
            end
         end
      end
   end

   task automatic do_op(input bit r, input bit w, input bit b, input logic [31:0] a,
                        input logic [31:0] wd, input string nm);
      cpu_exp_t    e;
      mem_exp_t    m;
      int unsigned ln = a >> 4;
      int          ix = ln % 4;
      int unsigned wa = a & ~32'd3;
      logic [31:0] word;
      bit          served = 0;
      e.name = nm;
      e.is_load = !w;
      e.stall = 0;
      e.rdata = '0;
      if (!(m_valid[ix] && m_line[ix] == ln)) begin
         if (m_valid[ix] && m_dirty[ix]) begin
            m.we = 1'b1;
            m.addr = m_line[ix] << 4;
            for (int k = 0; k < 4; k++) begin
               m.wdata[32*k +: 32] = get_cur(m.addr + 4*k);
               exp_mem[m.addr + 4*k] = get_cur(m.addr + 4*k);
            end
            mem_q.push_back(m);
            e.stall = 2*LAT + 3;
         end else begin
            e.stall = LAT + 2;
         end
         m.we = 1'b0;
         m.addr = ln << 4;
         m.wdata = '0;
         mem_q.push_back(m);
         m_valid[ix] = 1'b1;
         m_dirty[ix] = 1'b0;
         m_line[ix] = ln;
      end
      word = get_cur(wa);
      if (w) begin
         if (b)
            word[8*a[1:0] +: 8] = wd[7:0];
         else
            word = wd;
         cur_m[wa] = word;
         m_dirty[ix] = 1'b1;
      end else begin
         e.rdata = b ? {24'd0, word[8*a[1:0] +: 8]} : word;
      end
      cpu_q.push_back(e);

      mif.cpu_addr = a;
      mif.cpu_r_en = r;
      mif.cpu_w_en = w;
      mif.cpu_is_byte = b;
      mif.cpu_wdata = wd;
      for (int c = 0; c < 60 && !served; c++) begin
         @(negedge clk);
         if (!mif.block_pipe_data_cache)
            served = 1;
      end
      @(posedge clk);
      #1;
      mif.cpu_r_en = 1'b0;
      mif.cpu_w_en = 1'b0;
      if (!served)
         chk({nm, "_served"}, served, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      mem_exp_t m;
      logic [31:0] a;
      int op;
      mif.cpu_addr = '0;
      mif.cpu_r_en = 1'b0;
      mif.cpu_w_en = 1'b0;
      mif.cpu_is_byte = 1'b0;
      mif.cpu_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
         m_line[i] = 0;
      end

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_mem_req", mif.mem_req, 1'b0);
      chk("reset_mem_we", mif.mem_we, 1'b0);
      chk("reset_stall", mif.block_pipe_data_cache, 1'b0);
      chk("reset_rdata", mif.cpu_rdata, 32'd0);
      @(posedge clk);
      #1;

      do_op(1, 0, 0, 32'h40, 32'h0, "t1_ldw_cold");
      do_op(0, 1, 0, 32'h44, 32'hDEAD_BEEF, "t2_stw_hit");
      do_op(1, 0, 0, 32'h44, 32'h0, "t2_ldw_hit");
      do_op(1, 0, 0, 32'h84, 32'h0, "t3_ldw_evict");
      do_op(0, 1, 0, 32'h44, 32'h1122_3344, "t4_stw");
      do_op(0, 1, 1, 32'h47, 32'h0000_00AB, "t4_stb");
      do_op(1, 0, 1, 32'h47, 32'h0, "t4_ldb");
      do_op(1, 0, 0, 32'h44, 32'h0, "t4_ldw");

      // Abort a fill with reset in its third cycle.
      m.we = 1'b0;
      m.addr = 32'h1A0;
      m.wdata = '0;
      mem_q.push_back(m);
      mif.cpu_addr = 32'h1A0;
      mif.cpu_r_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      mif.cpu_r_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_q.delete();
      cpu_q.delete();
      cur_m = exp_mem;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
      @(negedge clk);
      chk("t5_mem_req", mif.mem_req, 1'b0);
      chk("t5_stall", mif.block_pipe_data_cache, 1'b0);
      @(posedge clk);
      #1;
      do_op(1, 0, 0, 32'h1A0, 32'h0, "t5_reaccess");
      do_op(1, 0, 0, 32'h44, 32'h0, "t5_lost_wback");

      do_op(1, 1, 0, 32'h1A4, 32'hCAFE_F00D, "t6_rw_store");
      spur_ack = 1'b1;
      @(posedge clk);
      #1;
      spur_ack = 1'b0;
      @(negedge clk);
      chk("t6_spur_ack_req", mif.mem_req, 1'b0);
      chk("t6_spur_ack_stall", mif.block_pipe_data_cache, 1'b0);
      @(posedge clk);
      #1;
      do_op(1, 0, 0, 32'h1A4, 32'h0, "t6_ldw");
      do_op(1, 0, 0, 32'h2A4, 32'h0, "t6_evict_dirty");

      for (int n = 0; n < 300; n++) begin
         a = $urandom & 32'h0000_03FF;
         op = $urandom_range(0, 4);
         case (op)
            0: do_op(1, 0, 0, a, 32'h0, "rnd_ldw");
            1: do_op(1, 0, 1, a, 32'h0, "rnd_ldb");
            2: do_op(0, 1, 0, a, $urandom, "rnd_stw");
            3: do_op(0, 1, 1, a, $urandom, "rnd_stb");
            default: do_op(1, 1, $urandom_range(0, 1), a, $urandom, "rnd_rw");
         endcase
      end

      repeat (3) @(posedge clk);
      #1;
      chk("cpu_q_drained", cpu_q.size(), 0);
      chk("mem_q_drained", mem_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
